// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU/branch reservation station with CDB wakeup and in-order-by-index issue
//
// Purpose: holds up to ENTRIES dispatched ALU/branch/jump instructions until
// both source operands are available. It then issues the lowest-index ready
// slot, one per cycle, to the execute unit through registered ex_* outputs.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   dispatch_en_i, OP_i, Funct7_i, Funct3_i, Imm_i, pc_i, ROB_id_i
//                                instruction dispatched into a free slot
//   Qj_busy_i/Qj_i/Vj_i          operand A: pending flag, producer tag, value
//   Qk_busy_i/Qk_i/Vk_i          operand B: pending flag, producer tag, value
//   full_o                       every slot is occupied
//   cdb_en_i/cdb_id_ROB_i/cdb_data_i
//                                common data bus result broadcast
//   flush_i                      discard all slots and this cycle's issue
//   ex_en_o, ex_A_o, ex_B_o, ex_Imm_o, ex_pc_o, ex_OP_o, ex_Funct7_o,
//   ex_Funct3_o, ex_ROB_id_o     registered issue to the execute unit
module alu_rs #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dispatch_en_i,
    input  logic [6:0]  OP_i,
    input  logic [6:0]  Funct7_i,
    input  logic [2:0]  Funct3_i,
    input  logic [31:0] Imm_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  ROB_id_i,
    input  logic        Qj_busy_i,
    input  logic [4:0]  Qj_i,
    input  logic [31:0] Vj_i,
    input  logic        Qk_busy_i,
    input  logic [4:0]  Qk_i,
    input  logic [31:0] Vk_i,
    output logic        full_o,
    input  logic        cdb_en_i,
    input  logic [4:0]  cdb_id_ROB_i,
    input  logic [31:0] cdb_data_i,
    input  logic        flush_i,
    output logic        ex_en_o,
    output logic [31:0] ex_A_o,
    output logic [31:0] ex_B_o,
    output logic [31:0] ex_Imm_o,
    output logic [31:0] ex_pc_o,
    output logic [6:0]  ex_OP_o,
    output logic [6:0]  ex_Funct7_o,
    output logic [2:0]  ex_Funct3_o,
    output logic [4:0]  ex_ROB_id_o
);
    localparam int IW = $clog2(ENTRIES);

    // Slot storage
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] qj_busy_q, qj_busy_d;
    logic [ENTRIES-1:0] qk_busy_q, qk_busy_d;
    logic [6:0]  op_q  [ENTRIES];
    logic [6:0]  op_d  [ENTRIES];
    logic [6:0]  f7_q  [ENTRIES];
    logic [6:0]  f7_d  [ENTRIES];
    logic [2:0]  f3_q  [ENTRIES];
    logic [2:0]  f3_d  [ENTRIES];
    logic [31:0] imm_q [ENTRIES];
    logic [31:0] imm_d [ENTRIES];
    logic [31:0] pc_q  [ENTRIES];
    logic [31:0] pc_d  [ENTRIES];
    logic [4:0]  rob_q [ENTRIES];
    logic [4:0]  rob_d [ENTRIES];
    logic [31:0] vj_q  [ENTRIES];
    logic [31:0] vj_d  [ENTRIES];
    logic [31:0] vk_q  [ENTRIES];
    logic [31:0] vk_d  [ENTRIES];
    logic [4:0]  qj_q  [ENTRIES];
    logic [4:0]  qj_d  [ENTRIES];
    logic [4:0]  qk_q  [ENTRIES];
    logic [4:0]  qk_d  [ENTRIES];

    // Issue output registers
    logic        ex_en_q, ex_en_d;
    logic [31:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
    logic [6:0]  ex_op_q, ex_op_d, ex_f7_q, ex_f7_d;
    logic [2:0]  ex_f3_q, ex_f3_d;
    logic [4:0]  ex_rob_q, ex_rob_d;

    logic [ENTRIES-1:0] ready_vec;
    logic [IW-1:0]      free_idx, issue_idx;
    logic               issue_found;
    logic               do_dispatch, do_issue;
    logic               byp_j, byp_k;
    logic [31:0]        vj_in, vk_in;

    assign full_o    = &busy_q;
    assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

    // Lowest-index priority encoders: scanning downward lets the lowest match win.
    always_comb begin
        free_idx    = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = IW'(i);
            end
            if (ready_vec[i]) begin
                issue_idx   = IW'(i);
                issue_found = 1'b1;
            end
        end
    end

    assign do_dispatch = dispatch_en_i & ~full_o & ~flush_i;
    assign do_issue    = issue_found & ~flush_i;

    // An operand whose producer is broadcasting this very cycle would otherwise
    // miss the wakeup, since the slot is not busy yet when the CDB is compared.
    assign byp_j = Qj_busy_i & cdb_en_i & (Qj_i == cdb_id_ROB_i);
    assign byp_k = Qk_busy_i & cdb_en_i & (Qk_i == cdb_id_ROB_i);
    assign vj_in = byp_j ? cdb_data_i : Vj_i;
    assign vk_in = byp_k ? cdb_data_i : Vk_i;

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        op_d  = op_q;
        f7_d  = f7_q;
        f3_d  = f3_q;
        imm_d = imm_q;
        pc_d  = pc_q;
        rob_d = rob_q;
        vj_d  = vj_q;
        vk_d  = vk_q;
        qj_d  = qj_q;
        qk_d  = qk_q;

        // Wakeup of waiting operands in occupied slots
        for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_en_i && busy_q[i] && qj_busy_q[i] && (qj_q[i] == cdb_id_ROB_i)) begin
                vj_d[i]      = cdb_data_i;
                qj_busy_d[i] = 1'b0;
            end
            if (cdb_en_i && busy_q[i] && qk_busy_q[i] && (qk_q[i] == cdb_id_ROB_i)) begin
                vk_d[i]      = cdb_data_i;
                qk_busy_d[i] = 1'b0;
            end
        end

        // Dispatch targets a free slot and issue a ready (busy) one, so they never collide.
        if (do_dispatch) begin
            busy_d[free_idx]    = 1'b1;
            op_d[free_idx]      = OP_i;
            f7_d[free_idx]      = Funct7_i;
            f3_d[free_idx]      = Funct3_i;
            imm_d[free_idx]     = Imm_i;
            pc_d[free_idx]      = pc_i;
            rob_d[free_idx]     = ROB_id_i;
            vj_d[free_idx]      = vj_in;
            vk_d[free_idx]      = vk_in;
            qj_d[free_idx]      = Qj_i;
            qk_d[free_idx]      = Qk_i;
            qj_busy_d[free_idx] = Qj_busy_i & ~byp_j;
            qk_busy_d[free_idx] = Qk_busy_i & ~byp_k;
        end

        if (do_issue) begin
            busy_d[issue_idx] = 1'b0;
        end

        if (flush_i) begin
            busy_d = '0;
        end
    end

    // Data fields hold their last values when nothing issues.
    always_comb begin
        ex_en_d  = do_issue;
        ex_a_d   = ex_a_q;
        ex_b_d   = ex_b_q;
        ex_imm_d = ex_imm_q;
        ex_pc_d  = ex_pc_q;
        ex_op_d  = ex_op_q;
        ex_f7_d  = ex_f7_q;
        ex_f3_d  = ex_f3_q;
        ex_rob_d = ex_rob_q;
        if (do_issue) begin
            ex_a_d   = vj_q[issue_idx];
            ex_b_d   = vk_q[issue_idx];
            ex_imm_d = imm_q[issue_idx];
            ex_pc_d  = pc_q[issue_idx];
            ex_op_d  = op_q[issue_idx];
            ex_f7_d  = f7_q[issue_idx];
            ex_f3_d  = f3_q[issue_idx];
            ex_rob_d = rob_q[issue_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            qj_busy_q <= '0;
            qk_busy_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]  <= '0;
                f7_q[i]  <= '0;
                f3_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                rob_q[i] <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
            ex_en_q  <= 1'b0;
            ex_a_q   <= '0;
            ex_b_q   <= '0;
            ex_imm_q <= '0;
            ex_pc_q  <= '0;
            ex_op_q  <= '0;
            ex_f7_q  <= '0;
            ex_f3_q  <= '0;
            ex_rob_q <= '0;
        end else begin
            busy_q    <= busy_d;
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            op_q  <= op_d;
            f7_q  <= f7_d;
            f3_q  <= f3_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
            rob_q <= rob_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            ex_en_q  <= ex_en_d;
            ex_a_q   <= ex_a_d;
            ex_b_q   <= ex_b_d;
            ex_imm_q <= ex_imm_d;
            ex_pc_q  <= ex_pc_d;
            ex_op_q  <= ex_op_d;
            ex_f7_q  <= ex_f7_d;
            ex_f3_q  <= ex_f3_d;
            ex_rob_q <= ex_rob_d;
        end
    end

    assign ex_en_o     = ex_en_q;
    assign ex_A_o      = ex_a_q;
    assign ex_B_o      = ex_b_q;
    assign ex_Imm_o    = ex_imm_q;
    assign ex_pc_o     = ex_pc_q;
    assign ex_OP_o     = ex_op_q;
    assign ex_Funct7_o = ex_f7_q;
    assign ex_Funct3_o = ex_f3_q;
    assign ex_ROB_id_o = ex_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs
module tb_alu_rs;
    logic        clk;
    logic        rst;
    logic        dispatch_en;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm, pc;
    logic [4:0]  rob;
    logic        qjb, qkb;
    logic [4:0]  qj, qk;
    logic [31:0] vj, vk;
    logic        full_o;
    logic        cdb_en;
    logic [4:0]  cdb_id;
    logic [31:0] cdb_data;
    logic        flush;
    logic        ex_en_o;
    logic [31:0] ex_A_o, ex_B_o, ex_Imm_o, ex_pc_o;
    logic [6:0]  ex_OP_o, ex_Funct7_o;
    logic [2:0]  ex_Funct3_o;
    logic [4:0]  ex_ROB_id_o;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    alu_rs #(.ENTRIES(8)) dut (
        .clk(clk), .rst(rst),
        .dispatch_en_i(dispatch_en), .OP_i(op), .Funct7_i(f7), .Funct3_i(f3),
        .Imm_i(imm), .pc_i(pc), .ROB_id_i(rob),
        .Qj_busy_i(qjb), .Qj_i(qj), .Vj_i(vj),
        .Qk_busy_i(qkb), .Qk_i(qk), .Vk_i(vk),
        .full_o(full_o),
        .cdb_en_i(cdb_en), .cdb_id_ROB_i(cdb_id), .cdb_data_i(cdb_data),
        .flush_i(flush),
        .ex_en_o(ex_en_o), .ex_A_o(ex_A_o), .ex_B_o(ex_B_o), .ex_Imm_o(ex_Imm_o),
        .ex_pc_o(ex_pc_o), .ex_OP_o(ex_OP_o), .ex_Funct7_o(ex_Funct7_o),
        .ex_Funct3_o(ex_Funct3_o), .ex_ROB_id_o(ex_ROB_id_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        dispatch_en = 0; op = '0; f7 = '0; f3 = '0; imm = '0; pc = '0; rob = '0;
        qjb = 0; qj = '0; vj = '0; qkb = 0; qk = '0; vk = '0;
        cdb_en = 0; cdb_id = '0; cdb_data = '0; flush = 0;
    endtask

    task automatic set_disp(input logic [6:0] o, input logic [2:0] fn3,
                            input logic [31:0] a, input logic ab, input logic [4:0] at,
                            input logic [31:0] b, input logic bb, input logic [4:0] bt,
                            input logic [31:0] im, input logic [4:0] r);
        dispatch_en = 1; op = o; f7 = 7'd0; f3 = fn3; imm = im;
        pc = 32'h1000 + {25'd0, r, 2'b00}; rob = r;
        vj = a; qjb = ab; qj = at; vk = b; qkb = bb; qk = bt;
    endtask

    task automatic test_reset;
        rst = 1;
        idle();
        #1;
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", ex_en_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
        checks++; if (ex_A_o !== 32'd0 || ex_pc_o !== 32'd0 || ex_ROB_id_o !== 5'd0) begin
            errors++; $display("FAIL reset_data: A=%h pc=%h rob=%h want 0", ex_A_o, ex_pc_o, ex_ROB_id_o); end
        checks++; if (dut.busy_q !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h want 00", dut.busy_q); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_addi;
        set_disp(OP_IMM, 3'b000, 32'd5, 0, 5'd0, 32'd0, 0, 5'd0, 32'd7, 5'd3);
        tick();
        idle();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL addi_e0_en: got %b want 0", ex_en_o); end
        tick();
        checks++; if (ex_en_o !== 1'b1) begin errors++; $display("FAIL addi_e1_en: got %b want 1", ex_en_o); end
        checks++; if (ex_A_o !== 32'd5 || ex_Imm_o !== 32'd7 || ex_ROB_id_o !== 5'd3) begin
            errors++; $display("FAIL addi_e1_data: A=%h imm=%h rob=%h want 5/7/3", ex_A_o, ex_Imm_o, ex_ROB_id_o); end
        checks++; if (ex_OP_o !== OP_IMM || ex_pc_o !== 32'h100C || ex_Funct3_o !== 3'b000) begin
            errors++; $display("FAIL addi_e1_ctl: op=%b pc=%h f3=%b want 0010011/100c/000", ex_OP_o, ex_pc_o, ex_Funct3_o); end
        tick();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL addi_e2_en: got %b want 0", ex_en_o); end
        checks++; if (ex_A_o !== 32'd5 || ex_ROB_id_o !== 5'd3) begin
            errors++; $display("FAIL addi_e2_hold: A=%h rob=%h want 5/3", ex_A_o, ex_ROB_id_o); end
    endtask

    task automatic test_wakeup;
        set_disp(OP_REG, 3'b000, 32'hDEAD, 1, 5'd9, 32'd3, 0, 5'd0, 32'd0, 5'd12);
        tick();
        idle();
        for (int e = 1; e <= 3; e++) begin
            if (e == 3) begin cdb_en = 1; cdb_id = 5'd9; cdb_data = 32'h10; end
            tick();
            checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL wake_noissue_e%0d: got %b want 0", e, ex_en_o); end
        end
        idle();
        tick();
        checks++; if (ex_en_o !== 1'b1) begin errors++; $display("FAIL wake_e4_en: got %b want 1", ex_en_o); end
        checks++; if (ex_A_o !== 32'h10 || ex_B_o !== 32'd3 || ex_ROB_id_o !== 5'd12) begin
            errors++; $display("FAIL wake_e4_data: A=%h B=%h rob=%h want 10/3/c", ex_A_o, ex_B_o, ex_ROB_id_o); end
    endtask

    task automatic test_bypass;
        set_disp(OP_REG, 3'b111, 32'h22, 0, 5'd0, 32'h1111, 1, 5'd4, 32'd0, 5'd13);
        cdb_en = 1; cdb_id = 5'd4; cdb_data = 32'hAB;
        tick();
        idle();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL byp_e0_en: got %b want 0", ex_en_o); end
        tick();
        checks++; if (ex_en_o !== 1'b1) begin errors++; $display("FAIL byp_e1_en: got %b want 1", ex_en_o); end
        checks++; if (ex_B_o !== 32'hAB || ex_A_o !== 32'h22 || ex_Funct3_o !== 3'b111) begin
            errors++; $display("FAIL byp_data: A=%h B=%h f3=%b want 22/ab/111", ex_A_o, ex_B_o, ex_Funct3_o); end
    endtask

    task automatic test_back_to_back;
        tick();
        set_disp(OP_REG, 3'b000, 32'h0, 1, 5'd7, 32'd1, 0, 5'd0, 32'd0, 5'd20);
        tick();
        set_disp(OP_REG, 3'b000, 32'h21, 0, 5'd0, 32'd2, 0, 5'd0, 32'd0, 5'd21);
        tick();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL b2b_pre_en: got %b want 0", ex_en_o); end
        set_disp(OP_REG, 3'b000, 32'h22, 0, 5'd0, 32'd3, 0, 5'd0, 32'd0, 5'd22);
        cdb_en = 1; cdb_id = 5'd7; cdb_data = 32'h77;
        tick();
        idle();
        checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'd21 || ex_A_o !== 32'h21) begin
            errors++; $display("FAIL b2b_first: en=%b rob=%0d A=%h want 1/21/21", ex_en_o, ex_ROB_id_o, ex_A_o); end
        tick();
        checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'd20 || ex_A_o !== 32'h77) begin
            errors++; $display("FAIL b2b_second: en=%b rob=%0d A=%h want 1/20/77", ex_en_o, ex_ROB_id_o, ex_A_o); end
        tick();
        checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'd22 || ex_A_o !== 32'h22) begin
            errors++; $display("FAIL b2b_third: en=%b rob=%0d A=%h want 1/22/22", ex_en_o, ex_ROB_id_o, ex_A_o); end
        tick();
        checks++; if (ex_en_o !== 1'b0 || dut.busy_q !== 8'h00) begin
            errors++; $display("FAIL b2b_drain: en=%b busy=%h want 0/00", ex_en_o, dut.busy_q); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) begin
            set_disp(OP_REG, 3'b000, 32'd0, 1, 5'd1, 32'(i), 0, 5'd0, 32'd0, 5'(10 + i));
            tick();
        end
        idle();
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full_o); end
        set_disp(OP_IMM, 3'b000, 32'h99, 0, 5'd0, 32'h99, 0, 5'd0, 32'd0, 5'd30);
        tick();
        idle();
        tick();
        checks++; if (full_o !== 1'b1 || ex_en_o !== 1'b0) begin
            errors++; $display("FAIL full_drop: full=%b en=%b want 1/0", full_o, ex_en_o); end
        cdb_en = 1; cdb_id = 5'd1; cdb_data = 32'h55;
        tick();
        idle();
        checks++; if (ex_en_o !== 1'b0 || full_o !== 1'b1) begin
            errors++; $display("FAIL full_wake: en=%b full=%b want 0/1", ex_en_o, full_o); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'(10 + i) || ex_A_o !== 32'h55 || ex_B_o !== 32'(i)) begin
                errors++; $display("FAIL full_issue%0d: en=%b rob=%0d A=%h B=%h want 1/%0d/55/%0d",
                                   i, ex_en_o, ex_ROB_id_o, ex_A_o, ex_B_o, 10 + i, i); end
            if (i == 0) begin
                checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL full_fall: got %b want 0", full_o); end
            end
        end
        tick();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL full_end: got %b want 0 (dropped dispatch issued)", ex_en_o); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_REG, 3'b000, 32'd0, 1, 5'd2, 32'd0, 0, 5'd0, 32'd0, 5'(1 + i));
            tick();
        end
        checks++; if (dut.busy_q !== 8'h07) begin errors++; $display("FAIL flush_fill: busy=%h want 07", dut.busy_q); end
        set_disp(OP_IMM, 3'b000, 32'h1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd25);
        flush = 1;
        tick();
        idle();
        checks++; if (full_o !== 1'b0 || ex_en_o !== 1'b0 || dut.busy_q !== 8'h00) begin
            errors++; $display("FAIL flush_clear: full=%b en=%b busy=%h want 0/0/00", full_o, ex_en_o, dut.busy_q); end
        cdb_en = 1; cdb_id = 5'd2; cdb_data = 32'h9;
        tick();
        idle();
        tick();
        checks++; if (ex_en_o !== 1'b0) begin errors++; $display("FAIL flush_noissue: got %b want 0", ex_en_o); end
        set_disp(OP_IMM, 3'b000, 32'h26, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd26);
        tick();
        idle();
        checks++; if (dut.busy_q !== 8'h01) begin errors++; $display("FAIL flush_slot0: busy=%h want 01", dut.busy_q); end
        tick();
        checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'd26) begin
            errors++; $display("FAIL flush_after: en=%b rob=%0d want 1/26", ex_en_o, ex_ROB_id_o); end
    endtask

    task automatic test_async_reset;
        tick();
        set_disp(OP_IMM, 3'b000, 32'h5A, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5);
        tick();
        set_disp(OP_REG, 3'b000, 32'd0, 1, 5'd8, 32'd0, 0, 5'd0, 32'd0, 5'd6);
        tick();
        idle();
        checks++; if (ex_en_o !== 1'b1 || dut.busy_q === 8'h00) begin
            errors++; $display("FAIL arst_pre: en=%b busy=%h want 1/nonzero", ex_en_o, dut.busy_q); end
        #2 rst = 1;
        #1;
        checks++; if (ex_en_o !== 1'b0 || ex_A_o !== 32'd0 || ex_ROB_id_o !== 5'd0 || dut.busy_q !== 8'h00) begin
            errors++; $display("FAIL arst_issue: en=%b A=%h rob=%h busy=%h want 0", ex_en_o, ex_A_o, ex_ROB_id_o, dut.busy_q); end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            set_disp(OP_REG, 3'b000, 32'd0, 1, 5'd8, 32'd0, 0, 5'd0, 32'd0, 5'(i));
            tick();
        end
        idle();
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL arst_fullpre: got %b want 1", full_o); end
        #2 rst = 1;
        #1;
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL arst_full: got %b want 0", full_o); end
        @(negedge clk);
        rst = 0;
        set_disp(OP_IMM, 3'b000, 32'h7, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7);
        tick();
        idle();
        checks++; if (dut.busy_q !== 8'h01) begin errors++; $display("FAIL arst_slot0: busy=%h want 01", dut.busy_q); end
        tick();
        checks++; if (ex_en_o !== 1'b1 || ex_ROB_id_o !== 5'd7 || ex_A_o !== 32'h7) begin
            errors++; $display("FAIL arst_after: en=%b rob=%0d A=%h want 1/7/7", ex_en_o, ex_ROB_id_o, ex_A_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_full();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter ENTRIES, default 8: number of reservation-station slots, power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 dispatch_en_i  input  1  dispatch request for one ALU/branch/jump instruction this cycle.
REQ-005 OP_i  input  7  opcode; Funct7_i  input  7; Funct3_i  input  3.
REQ-006 Imm_i  input  32  immediate; pc_i  input  32  instruction PC; ROB_id_i  input  5  destination ROB tag.
REQ-007 Qj_busy_i  input  1  operand A pending; Qj_i  input  5  producing ROB tag; Vj_i  input  32  value when not pending.
REQ-008 Qk_busy_i, Qk_i, Vk_i  input  1/5/32  same for operand B.
REQ-009 full_o  output  1  no free slot; the dispatcher holds dispatch_en_i low while high.
REQ-010 cdb_en_i  input  1; cdb_id_ROB_i  input  5; cdb_data_i  input  32  result broadcast.
REQ-011 flush_i  input  1  misprediction flush.
REQ-012 ex_en_o  output  1; ex_A_o, ex_B_o, ex_Imm_o, ex_pc_o  output  32 each; ex_OP_o  output  7; ex_Funct7_o  output  7; ex_Funct3_o  output  3; ex_ROB_id_o  output  5: registered issue to the execute unit.

Function
REQ-013 Each slot holds busy, OP, Funct7, Funct3, Imm, pc, ROB_id, and Vj/Qj/Qj_busy, Vk/Qk/Qk_busy.
REQ-014 full_o is combinational from registered state: high when all ENTRIES slots are busy.
REQ-015 Dispatch with dispatch_en_i=1, full_o=0, flush_i=0 writes the lowest-index non-busy slot; busy=1 after the edge.
REQ-016 Dispatch while full_o=1 is dropped; no slot changes.
REQ-017 Wakeup: when cdb_en_i=1, every busy slot whose Qj_busy=1 and Qj==cdb_id_ROB_i takes Vj=cdb_data_i and Qj_busy=0 at the edge; same for Qk.
REQ-018 Dispatch bypass: an incoming operand pending on a tag equal to cdb_id_ROB_i while cdb_en_i=1 is stored as ready with cdb_data_i.
REQ-019 Ready = busy and Qj_busy=0 and Qk_busy=0, evaluated on registered state; a slot woken at edge N is ready in cycle N+1.
REQ-020 Issue select: the lowest-index ready slot; at the edge it drives all ex_* fields from that slot, sets ex_en_o=1, and clears its busy.
REQ-021 No ready slot: ex_en_o=0 after the edge; other ex_* outputs hold their previous values.
REQ-022 Issue throughput: one instruction per cycle; latency from a dispatch with both operands ready at edge N to ex_en_o=1 is edge N+1.
REQ-023 Free-then-reuse: a slot freed by issue at edge N is eligible for dispatch in cycle N+1, not cycle N.
REQ-024 Simultaneous dispatch, wakeup, and issue in one cycle are all performed; they touch distinct slots by construction.
REQ-025 Flush: when flush_i=1, at the edge all busy bits are cleared, ex_en_o=0, and any dispatch or issue that cycle is discarded.
REQ-026 The block performs no arithmetic; operands pass unchanged, bit-exact.

Reset
REQ-027 While rst=1, with no clock required: all busy bits=0, every stored field=0, ex_en_o=0, all ex_* data outputs=0, full_o=0.
REQ-028 Reset asserted mid-operation discards all in-flight slots; the first dispatch after deassertion lands in slot 0.

Verification
REQ-029 Dispatch ADDI (OP=0010011, F3=000, Vj=5, Imm=7, ROB_id=3, both operands ready) at edge 0 -> edge 1: ex_en_o=1, ex_A_o=5, ex_Imm_o=7, ex_ROB_id_o=3; edge 2: ex_en_o=0.
REQ-030 Dispatch ADD with Qj_busy=1, Qj=9; at edge 3, cdb_en_i=1, cdb_id_ROB_i=9, cdb_data_i=0x10 -> no issue through edge 3; edge 4: ex_en_o=1, ex_A_o=0x10.
REQ-031 Dispatch with Qk pending on tag 4 while the CDB broadcasts tag 4 with data 0xAB in the same cycle -> issues at the next edge with ex_B_o=0xAB.
REQ-032 Dispatch ENTRIES instructions all waiting on tag 1 -> full_o=1; an extra dispatch is dropped; broadcast tag 1 -> the slots issue in index order, one per cycle, and full_o falls after the first issue.
REQ-033 Fill 3 slots, assert flush_i for one cycle -> full_o=0, ex_en_o=0 thereafter, and the next dispatch lands in slot 0.
REQ-034 Assert rst asynchronously between edges while slots are busy and ex_en_o=1 -> ex_en_o=0 and full_o=0 immediately, without waiting for a clock edge.
